// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame link: frame states, line idle
// level and a helper that gives the frame length in clocks.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Clocks from the first start-bit clock to the last stop-bit clock.
  function automatic int frame_clocks(input int data_w, input int div, input bit parity_en);
    return (data_w + 2 + (parity_en ? 1 : 0)) * div;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer for the serial link (used by both transmit and receive
// ends). Counts 0..DIV-1 and raises tick on the last count of each bit.
// clear holds the count at 0 so the first bit after idle is full length.
module serial_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] count;

  assign tick = (count == TW'(DIV - 1));

  // Free-running bit counter, wraps after the last clock of each bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB
// first, optional even parity, stop bit; every bit lasts DIV clocks.
// Optional parity bit is compiled in with SERIAL_FRAME_TX_PARITY_EN.
// All outputs are decoded from registered state only.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic              tick;
  logic              timer_clear;
  logic              accept;
  logic              last_bit;
  logic [DATA_W-1:0] shift;
  logic [CW-1:0]     bit_cnt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              parity;
`endif

  assign timer_clear = (state == IDLE);
  assign accept      = in_valid && in_ready;
  assign last_bit    = (bit_cnt == CW'(DATA_W - 1));

  serial_bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .tick  (tick)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; ready/done/tx depend on state and tick only.
  always_comb begin
    state_nxt = state;
    tx_out    = LINE_IDLE;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = START;
        end
      end
      START: begin
        tx_out = 1'b0;
        if (tick) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        tx_out = shift[0];
        if (tick && last_bit) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
        tx_out = parity;
        if (tick) begin
          state_nxt = STOP;
        end
`else
        state_nxt = IDLE;
`endif
      end
      STOP: begin
        tx_out = LINE_IDLE;
        if (tick) begin
          done      = 1'b1;
          in_ready  = 1'b1;
          state_nxt = in_valid ? START : IDLE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and data bit counter: load on accept, shift per data bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shift   <= in_data;
      bit_cnt <= '0;
    end else if (state == DATA && tick) begin
      shift   <= shift >> 1;
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

`ifdef SERIAL_FRAME_TX_PARITY_EN
  // Even parity of the accepted word, captured before shifting starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^in_data;
    end
  end
`endif

endmodule
